// File: rtl/adder_result_buffer_if.sv
// Bundle connecting the adder result buffer to the adder-side producer and the checker-side consumer.
// The producer side drives the in_* tuple and out_ready; the buffer side drives the head entry and its status.
interface adder_result_buffer_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [3:0]       in_iop1;
  logic [3:0]       in_iop2;
  logic [4:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_iop1;
  logic [3:0]       out_iop2;
  logic [4:0]       out_op;
  logic             out_err;
  logic [LVL_W-1:0] level;
  logic             full;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_iop1, in_iop2, in_op, out_ready,
    input  out_valid, out_iop1, out_iop2, out_op, out_err, level, full, err_cnt, drop_cnt
  );

  modport slave (
    input  in_valid, in_iop1, in_iop2, in_op, out_ready,
    output out_valid, out_iop1, out_iop2, out_op, out_err, level, full, err_cnt, drop_cnt
  );
endinterface

// File: rtl/adder_result_buffer.sv
// FIFO behind the 4-bit adder: stores {iop1, iop2, op} with a self-check error tag and drains over valid/ready.
// The adder cannot be stalled, so tuples arriving while full are dropped and counted.
module adder_result_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_result_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 14;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] drop_cnt;

  logic             out_valid;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [4:0]       sum;
  logic             in_err;
  logic [ENT_W-1:0] head;

  assign out_valid = (level != '0);
  assign full      = (level == LVL_W'(DEPTH));
  assign pop       = out_valid & bus.out_ready;
  assign push      = bus.in_valid & (~full | pop);
  assign drop      = bus.in_valid & full & ~pop;

  // Full 5-bit compare so a carry out of the operands is checked, not truncated.
  assign sum    = {1'b0, bus.in_iop1} + {1'b0, bus.in_iop2};
  assign in_err = (bus.in_op != sum);

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {in_err, bus.in_iop1, bus.in_iop2, bus.in_op};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && in_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign head = out_valid ? mem[rd_ptr] : '0;

  assign bus.out_valid = out_valid;
  assign bus.out_err   = head[13];
  assign bus.out_iop1  = head[12:9];
  assign bus.out_iop2  = head[8:5];
  assign bus.out_op    = head[4:0];
  assign bus.level     = level;
  assign bus.full      = full;
  assign bus.err_cnt   = err_cnt;
  assign bus.drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer: directed scenarios plus random traffic against a queue model.
// A second instance with 2-bit counters covers counter saturation.
module tb_adder_result_buffer;
  localparam int DEPTH = 8;
  localparam int CMAX  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [13:0] mq [$];
  int          m_err = 0;
  int          m_drop = 0;

  adder_result_buffer_if #(.DEPTH(8), .CNT_W(8)) bus ();
  adder_result_buffer_if #(.DEPTH(8), .CNT_W(2)) bus_s ();

  adder_result_buffer #(.DEPTH(8), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  adder_result_buffer #(.DEPTH(8), .CNT_W(2)) dut_s (.clk(clk), .rst(rst_s), .bus(bus_s));

  always #5 clk = ~clk;

  task automatic model_update(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                              input logic [4:0] o, input logic rdy);
    bit m_pop, m_push, m_drp, m_full, e;
    if (r) begin
      mq.delete();
      m_err  = 0;
      m_drop = 0;
      return;
    end
    m_full = (mq.size() == DEPTH);
    m_pop  = (mq.size() > 0) && rdy;
    m_push = v && (!m_full || m_pop);
    m_drp  = v && m_full && !m_pop;
    if (m_pop) void'(mq.pop_front());
    if (m_push) begin
      e = (int'(o) != int'(a) + int'(b));
      mq.push_back({e, a, b, o});
      if (e && m_err < CMAX) m_err++;
    end
    if (m_drp && m_drop < CMAX) m_drop++;
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [4:0] o, input logic rdy);
    rst          = r;
    bus.in_valid = v;
    bus.in_iop1  = a;
    bus.in_iop2  = b;
    bus.in_op    = o;
    bus.out_ready = rdy;
    model_update(r, v, a, b, o, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    n_checks++;
    if ({bus.out_valid, bus.level, bus.full, bus.err_cnt, bus.drop_cnt, bus.out_op} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0d level=%0d full=%0d err=%0d drop=%0d op=%0d, want all 0",
               bus.out_valid, bus.level, bus.full, bus.err_cnt, bus.drop_cnt, bus.out_op);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hold;
    step(1, 3, 4, 7, 0, 0);
    step(0, 1, 3, 4, 7, 0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.out_iop1, bus.out_iop2, bus.out_op, bus.out_err} !== {1'b1, 4'd3, 4'd4, 5'd7, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_head[%0d]: got v=%0d %0d,%0d,%0d err=%0d, want v=1 3,4,7 err=0",
                 i, bus.out_valid, bus.out_iop1, bus.out_iop2, bus.out_op, bus.out_err);
      end
      if (i < 5) step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_pop: got level=%0d valid=%0d, want 0 0", bus.level, bus.out_valid);
    end
  endtask

  task automatic test_err;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 15, 15, 30, 0);
    step(0, 1, 15, 1, 0, 0);
    n_checks++;
    if (bus.out_err !== 1'b0 || bus.err_cnt !== 8'd1 || bus.out_op !== 5'd30) begin
      n_fail++;
      $display("FAIL err_first: got err=%0d cnt=%0d op=%0d, want 0 1 30", bus.out_err, bus.err_cnt, bus.out_op);
    end
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (bus.out_err !== 1'b1 || bus.out_iop2 !== 4'd1 || bus.out_op !== 5'd0) begin
      n_fail++;
      $display("FAIL err_second: got err=%0d iop2=%0d op=%0d, want 1 1 0", bus.out_err, bus.out_iop2, bus.out_op);
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 4'(i), 4'(i), 5'((2 * i) % 32), 0);
    n_checks++;
    if (bus.level !== 4'd8 || bus.full !== 1'b1 || bus.drop_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL overflow_state: got level=%0d full=%0d drop=%0d, want 8 1 2", bus.level, bus.full, bus.drop_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.out_iop1, bus.out_iop2, bus.out_op} !== {1'b1, 4'(i), 4'(i), 5'(2 * i)}) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: got v=%0d %0d,%0d,%0d, want 1 %0d,%0d,%0d",
                 i, bus.out_valid, bus.out_iop1, bus.out_iop2, bus.out_op, i, i, 2 * i);
      end
      step(0, 0, 0, 0, 0, 1);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: got valid=%0d, want 0", bus.out_valid);
    end
  endtask

  task automatic test_full_push_pop;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 4'(15 - i), 5'(15), 0);
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if ({bus.out_iop1, bus.out_iop2, bus.out_op} !== mq[0][12:0]) begin
        n_fail++;
        $display("FAIL wrap_head[%0d]: got %h, want %h", k, {bus.out_iop1, bus.out_iop2, bus.out_op}, mq[0][12:0]);
      end
      step(0, 1, 4'(k + 3), 4'(k), 5'(2 * k + 3), 1);
      n_checks++;
      if (bus.level !== 4'd8 || bus.drop_cnt !== 8'd0 || bus.full !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_level[%0d]: got level=%0d drop=%0d full=%0d, want 8 0 1", k, bus.level, bus.drop_cnt, bus.full);
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({bus.out_err, bus.out_iop1, bus.out_iop2, bus.out_op} !== mq[0]) begin
        n_fail++;
        $display("FAIL wrap_drain[%0d]: got %h, want %h", k, {bus.out_err, bus.out_iop1, bus.out_iop2, bus.out_op}, mq[0]);
      end
      step(0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_reset_midstream;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 4'(i), 4'(i), 5'(0), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (bus.level !== 4'd5 || bus.err_cnt !== 8'(m_err) || bus.drop_cnt !== 8'd2 || m_err != 7) begin
      n_fail++;
      $display("FAIL pre_reset: got level=%0d err=%0d drop=%0d, want 5 7 2", bus.level, bus.err_cnt, bus.drop_cnt);
    end
    step(1, 1, 2, 2, 4, 1);
    n_checks++;
    if ({bus.level, bus.out_valid, bus.err_cnt, bus.drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got level=%0d valid=%0d err=%0d drop=%0d, want all 0",
               bus.level, bus.out_valid, bus.err_cnt, bus.drop_cnt);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturate;
    bus_s.in_iop1 = 4'd1;
    bus_s.in_iop2 = 4'd2;
    bus_s.in_op   = 5'd9;
    bus_s.out_ready = 1'b0;
    bus_s.in_valid = 1'b0;
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
    bus_s.in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
    end
    bus_s.in_valid = 1'b0;
    n_checks++;
    if (bus_s.drop_cnt !== 2'd3 || bus_s.err_cnt !== 2'd3 || bus_s.level !== 4'd8) begin
      n_fail++;
      $display("FAIL saturate: got drop=%0d err=%0d level=%0d, want 3 3 8", bus_s.drop_cnt, bus_s.err_cnt, bus_s.level);
    end
  endtask

  task automatic test_random;
    logic [3:0]  a, b;
    logic [4:0]  o;
    logic [13:0] eh;
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      o = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(a + b);
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), a, b, o,
           1'($urandom_range(0, 2) == 0 ? 1 : k[6]));
      eh = (mq.size() > 0) ? mq[0] : 14'd0;
      n_checks++;
      if ({bus.out_valid, bus.out_err, bus.out_iop1, bus.out_iop2, bus.out_op, bus.level, bus.full,
           bus.err_cnt, bus.drop_cnt} !==
          {mq.size() > 0, eh, 4'(mq.size()), mq.size() == DEPTH, 8'(m_err), 8'(m_drop)}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0d head=%h level=%0d full=%0d err=%0d drop=%0d, want v=%0d head=%h level=%0d err=%0d drop=%0d",
                 k, bus.out_valid, {bus.out_err, bus.out_iop1, bus.out_iop2, bus.out_op}, bus.level, bus.full,
                 bus.err_cnt, bus.drop_cnt, mq.size() > 0, eh, mq.size(), m_err, m_drop);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_iop1 = '0;
    bus.in_iop2 = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b0;
    bus_s.in_valid = 1'b0;
    bus_s.in_iop1 = '0;
    bus_s.in_iop2 = '0;
    bus_s.in_op = '0;
    bus_s.out_ready = 1'b0;
    #1;
    test_reset();
    test_hold();
    test_err();
    test_overflow();
    test_full_push_pop();
    test_reset_midstream();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
